// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO)
// Operands are converted to magnitudes, iterated one bit per cycle, then sign-fixed.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    sa        = ~op[0] & a[WIDTH-1];
    sb        = ~op[0] & b[WIDTH-1];
    mag_a     = sa ? -a : a;
    mag_b     = sb ? -b : b;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    // Top bit set means the trial subtraction borrowed: restore (keep shifted value).
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    dz_d     = dz_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (mthi) hi_d = wd;
        if (mtlo) lo_d = wd;
        if (start) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          cnt_d    = '0;
          acc_d    = {{WIDTH{1'b0}}, mag_a};
          opb_d    = mag_b;
          is_div_d = op[1];
          neg_d    = sa ^ sb;
          rneg_d   = sa;
          dz_d     = op[1] && (b == '0);
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (is_div_q) begin
          if (div_trial[WIDTH]) acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
          else                  acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      FIX: begin
        state_d = DONE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = dz_q ? {WIDTH{1'b1}} : quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wd;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wd(wd), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .dz(dz)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 1;
    busy_cnt = int'(busy);
    while (!done && edges < 60) begin
      tick();
      edges++;
      busy_cnt += int'(busy);
    end
  endtask

  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int e, bc;
    launch(o, x, y);
    wait_done(e, bc);
    check({name, " latency"}, e, 34);
    check({name, " busy_edges"}, bc, 33);
  endtask

  // Reference results from plain 64-bit integer arithmetic.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
    longint          sx, sy, p, q, r;
    longint unsigned ux, uy, up, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = 64'(x);
    uy = 64'(y);
    rdz = 1'b0;
    case (o)
      2'd0: begin p = sx * sy; rhi = p[63:32]; rlo = p[31:0]; end
      2'd1: begin up = ux * uy; rhi = up[63:32]; rlo = up[31:0]; end
      2'd2: begin
        if (y == 0) begin rdz = 1'b1; rhi = x; rlo = 32'hFFFFFFFF; end
        else begin q = sx / sy; r = sx % sy; rhi = r[31:0]; rlo = q[31:0]; end
      end
      default: begin
        if (y == 0) begin rdz = 1'b1; rhi = x; rlo = 32'hFFFFFFFF; end
        else begin uq = ux / uy; ur = ux % uy; rhi = ur[31:0]; rlo = uq[31:0]; end
      end
    endcase
  endfunction

  initial begin
    int          e, bc, done_seen;
    logic [31:0] hb, lb, ehi, elo;
    logic        edz;

    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; a = '0; b = '0; wd = '0;

    vecs[0] = '{2'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{2'd3, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5] = '{2'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[6] = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[7] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

    tick();
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset dz", dz, 0);
    tick();
    reset = 1'b1;
    tick();

    mthi = 1'b1; wd = 32'h1234;
    tick();
    mthi = 1'b0;
    check("mthi idle", hi, 32'h1234);
    check("mthi lo untouched", lo, 0);

    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d lo", i), lo, vecs[i].lo);
      check($sformatf("vec%0d dz", i), dz, vecs[i].dz);
      tick();
      check($sformatf("vec%0d done pulse", i), done, 0);
      check($sformatf("vec%0d dz held", i), dz, vecs[i].dz);
    end

    // Restarts and moves while running are ignored.
    launch(2'd0, 32'd7, 32'd9);
    hb = hi; lb = lo;
    for (int k = 2; k <= 34; k++) begin
      start = (k == 5 || k == 20);
      op = 2'd3; a = 32'd1000; b = 32'd3;
      mthi = (k == 10); mtlo = (k == 10); wd = 32'hDEADBEEF;
      tick();
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      if (k == 10) begin
        check("mthi during run", hi, hb);
        check("mtlo during run", lo, lb);
      end
    end
    check("ignored start done", done, 1);
    check("ignored start hi", hi, 0);
    check("ignored start lo", lo, 63);

    // Back-to-back accept while in DONE.
    launch(2'd3, 32'd100, 32'd7);
    check("b2b busy", busy, 1);
    check("b2b done", done, 0);
    wait_done(e, bc);
    check("b2b latency", e, 34);
    check("b2b lo", lo, 14);
    check("b2b hi", hi, 2);

    // Same-edge start and mthi: move lands, result overwrites later.
    start = 1'b1; op = 2'd1; a = 32'd6; b = 32'd7; mthi = 1'b1; wd = 32'h5555;
    tick();
    start = 1'b0; mthi = 1'b0;
    check("start+mthi hi", hi, 32'h5555);
    check("start+mthi busy", busy, 1);
    wait_done(e, bc);
    check("start+mthi result hi", hi, 0);
    check("start+mthi result lo", lo, 42);

    // Reset in the middle of a run.
    launch(2'd0, 32'd3, 32'd5);
    for (int k = 0; k < 9; k++) tick();
    check("pre-reset busy", busy, 1);
    reset = 1'b0;
    #1;
    check("async reset hi", hi, 0);
    check("async reset lo", lo, 0);
    check("async reset busy", busy, 0);
    check("async reset done", done, 0);
    tick();
    tick();
    reset = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      done_seen += int'(done);
    end
    check("no done after reset", done_seen, 0);
    do_op("post-reset divu", 2'd3, 32'd9, 32'd4);
    check("post-reset lo", lo, 2);
    check("post-reset hi", hi, 1);

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h80000000;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      ref_model(ro, ra, rb, ehi, elo, edz);
      do_op($sformatf("rnd%0d", n), ro, ra, rb);
      check($sformatf("rnd%0d op%0d %h,%h hi", n, ro, ra, rb), hi, ehi);
      check($sformatf("rnd%0d op%0d %h,%h lo", n, ro, ra, rb), lo, elo);
      check($sformatf("rnd%0d dz", n), dz, edz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin operation op on a, b.
REQ-005 SHALL have port: op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports: a, b  input  WIDTH  operands from regfile read ports rd1 (rs), rd2 (rt).
REQ-007 SHALL have ports: mthi, mtlo  input  1  direct write of wd into HI / LO.
REQ-008 SHALL have port: wd  input  WIDTH  data for mthi/mtlo.
REQ-009 SHALL have port: busy  output  1  operation in progress; stall request to pipeline.
REQ-010 SHALL have port: done  output  1  one-cycle pulse: HI/LO just updated by an operation.
REQ-011 SHALL have ports: hi, lo  output  WIDTH  architectural HI/LO registers, for MFHI/MFLO writeback mux.
REQ-012 SHALL have port: dz  output  1  last completed divide had b == 0; valid while done high and held until next accept.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; start in RUN/FIX ignored, no state change.
REQ-015 SHALL on accept latch op, |a|/|b| (signed ops) or a/b (unsigned ops), result sign, and dz = (op[1] && b == 0); load counter 0; go to RUN.
REQ-016 SHALL in RUN perform one radix-2 step per cycle (shift-add multiply / restoring divide) on a 2*WIDTH accumulator; after WIDTH RUN cycles go to FIX.
REQ-017 SHALL in FIX apply sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign.
REQ-018 SHALL on the FIX->DONE edge write HI = product[2W-1:W] / remainder, LO = product[W-1:0] / quotient.
REQ-019 SHALL hold done = 1 exactly in DONE; DONE -> IDLE next edge unless a new start is accepted (then -> RUN).
REQ-020 SHALL assert busy in RUN and FIX only; latency from accept edge to done high = WIDTH + 2 edges (34 at WIDTH=32).
REQ-021 SHALL on divide-by-zero run the full latency and produce LO = all ones, HI = a (dividend unmodified), dz = 1, for DIV and DIVU.
REQ-022 SHALL for DIV 0x80000000 / 0xFFFFFFFF produce LO = 0x80000000, HI = 0, dz = 0.
REQ-023 SHALL write HI (mthi) or LO (mtlo) with wd at the edge when state is IDLE or DONE; mthi/mtlo while busy ignored.
REQ-024 SHALL on same-edge start and mthi/mtlo accept start and perform the move; operation result later overwrites HI/LO.
REQ-025 SHALL keep hi/lo unchanged except by REQ-018, REQ-023, or reset.
REQ-026 SHALL drive hi, lo, busy, done, dz directly from registers (no combinational path from inputs).

Reset
REQ-027 SHALL while reset low force state IDLE, counter 0, hi = 0, lo = 0, busy = 0, done = 0, dz = 0, independent of clk.
REQ-028 SHALL abandon any in-flight operation on reset; HI/LO not written by it; first accept after reset release behaves as from power-up.

Verification
REQ-029 SHALL test MULT a=0xFFFFFFFD (-3), b=5 -> after 34 edges done=1, HI=0xFFFFFFFF, LO=0xFFFFFFF1, busy high edges 1..33.
REQ-030 SHALL test MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 SHALL test DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, dz=0; DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=0x64, dz=1.
REQ-032 SHALL test start pulsed with different operands at edges 5 and 20 of a running MULT -> ignored, result matches first operands only; back-to-back start during DONE accepted.
REQ-033 SHALL test reset low at RUN cycle 10 -> hi=lo=0, busy=0 immediately; no done pulse; next DIVU 9/4 -> LO=2, HI=1.
REQ-034 SHALL test mthi wd=0x1234 in IDLE -> hi=0x1234 next edge; mtlo during RUN -> lo unchanged.
